// File: rtl/spec_rangebin_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : spec_rangebin_seq_pkg
// Brief   : Shared sizes and FSM state type for the range-bin sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package spec_rangebin_seq_pkg;
    localparam int FFT_LEN  = 1024;
    localparam int IDX_W    = 10;
    localparam int RB_W     = 5;
    localparam int PIPE_LAT = 4;
    localparam int PWR_W    = 32;
    localparam int SMP_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_STREAM     = 2'd2,
        ST_DRAIN      = 2'd3
    } seq_state_t;
endpackage
`default_nettype wire

// File: rtl/spec_rangebin_seq_power_pipe.sv
`default_nettype none
// ============================================================================
// Module : spec_power_pipe
// Brief  : 4-stage re^2 + im^2 unit with delay-matched valid/index sideband.
// Rev    : 1.0  initial release
// ============================================================================
module spec_power_pipe
    import spec_rangebin_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [IDX_W-1:0]        in_index,
    input  logic signed [SMP_W-1:0] in_re,
    input  logic signed [SMP_W-1:0] in_im,
    output logic                    out_valid,
    output logic [IDX_W-1:0]        out_index,
    output logic [PWR_W-1:0]        out_power
);
    logic                    r_s1_vld_q, w_s1_vld_d;
    logic [IDX_W-1:0]        r_s1_idx_q, w_s1_idx_d;
    logic signed [SMP_W-1:0] r_s1_re_q, w_s1_re_d, r_s1_im_q, w_s1_im_d;
    logic                    r_s2_vld_q, w_s2_vld_d;
    logic [IDX_W-1:0]        r_s2_idx_q, w_s2_idx_d;
    logic [PWR_W-1:0]        r_s2_re2_q, w_s2_re2_d, r_s2_im2_q, w_s2_im2_d;
    logic                    r_s3_vld_q, w_s3_vld_d;
    logic [IDX_W-1:0]        r_s3_idx_q, w_s3_idx_d;
    logic [PWR_W-1:0]        r_s3_pwr_q, w_s3_pwr_d;
    logic                    r_s4_vld_q, w_s4_vld_d;
    logic [IDX_W-1:0]        r_s4_idx_q, w_s4_idx_d;
    logic [PWR_W-1:0]        r_s4_pwr_q, w_s4_pwr_d;
    logic signed [PWR_W-1:0] w_re_ext, w_im_ext;

    // Squares of 16-bit signed values fit in 31 bits, so their sum never wraps.
    always_comb begin
        w_re_ext   = PWR_W'(r_s1_re_q);
        w_im_ext   = PWR_W'(r_s1_im_q);
        w_s1_vld_d = in_valid & ~flush;
        w_s1_idx_d = in_valid ? in_index : r_s1_idx_q;
        w_s1_re_d  = in_valid ? in_re : r_s1_re_q;
        w_s1_im_d  = in_valid ? in_im : r_s1_im_q;
        w_s2_vld_d = r_s1_vld_q & ~flush;
        w_s2_idx_d = r_s1_vld_q ? r_s1_idx_q : r_s2_idx_q;
        w_s2_re2_d = r_s1_vld_q ? $unsigned(w_re_ext * w_re_ext) : r_s2_re2_q;
        w_s2_im2_d = r_s1_vld_q ? $unsigned(w_im_ext * w_im_ext) : r_s2_im2_q;
        w_s3_vld_d = r_s2_vld_q & ~flush;
        w_s3_idx_d = r_s2_vld_q ? r_s2_idx_q : r_s3_idx_q;
        w_s3_pwr_d = r_s2_vld_q ? (r_s2_re2_q + r_s2_im2_q) : r_s3_pwr_q;
        w_s4_vld_d = r_s3_vld_q & ~flush;
        w_s4_idx_d = r_s3_vld_q ? r_s3_idx_q : r_s4_idx_q;
        w_s4_pwr_d = r_s3_vld_q ? r_s3_pwr_q : r_s4_pwr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld_q <= 1'b0; r_s1_idx_q <= '0; r_s1_re_q  <= '0; r_s1_im_q  <= '0;
            r_s2_vld_q <= 1'b0; r_s2_idx_q <= '0; r_s2_re2_q <= '0; r_s2_im2_q <= '0;
            r_s3_vld_q <= 1'b0; r_s3_idx_q <= '0; r_s3_pwr_q <= '0;
            r_s4_vld_q <= 1'b0; r_s4_idx_q <= '0; r_s4_pwr_q <= '0;
        end else begin
            r_s1_vld_q <= w_s1_vld_d; r_s1_idx_q <= w_s1_idx_d;
            r_s1_re_q  <= w_s1_re_d;  r_s1_im_q  <= w_s1_im_d;
            r_s2_vld_q <= w_s2_vld_d; r_s2_idx_q <= w_s2_idx_d;
            r_s2_re2_q <= w_s2_re2_d; r_s2_im2_q <= w_s2_im2_d;
            r_s3_vld_q <= w_s3_vld_d; r_s3_idx_q <= w_s3_idx_d; r_s3_pwr_q <= w_s3_pwr_d;
            r_s4_vld_q <= w_s4_vld_d; r_s4_idx_q <= w_s4_idx_d; r_s4_pwr_q <= w_s4_pwr_d;
        end
    end

    assign out_valid = r_s4_vld_q;
    assign out_index = r_s4_idx_q;
    assign out_power = r_s4_pwr_q;
endmodule
`default_nettype wire

// File: rtl/spec_rangebin_seq.sv
`default_nettype none
// ============================================================================
// Module : spec_rangebin_seq
// Brief  : Per-shot range-bin sequencer framing FFT unload into power samples.
// Rev    : 1.0  initial release
// ============================================================================
module spec_rangebin_seq
    import spec_rangebin_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trig_start,
    input  logic [RB_W-1:0]         RangeBin_Num,
    input  logic                    fft_dv,
    input  logic [IDX_W-1:0]        fft_xk_index,
    input  logic signed [SMP_W-1:0] fft_xk_re,
    input  logic signed [SMP_W-1:0] fft_xk_im,
    output logic [IDX_W-1:0]        xk_index_reg1,
    output logic [IDX_W-1:0]        data_index,
    output logic                    data_valid_out,
    output logic [PWR_W-1:0]        spec_data_out,
    output logic [RB_W-1:0]         RangeBin_Counter,
    output logic                    seq_busy,
    output logic                    seq_done,
    output logic                    index_err,
    output logic                    overlap_err
);
    localparam int DRAIN_W = $clog2(PIPE_LAT);

    seq_state_t         r_state_q, w_state_d;
    logic [IDX_W-1:0]   r_exp_idx_q, w_exp_idx_d;
    logic [IDX_W-1:0]   r_xk_idx_q, w_xk_idx_d;
    logic [DRAIN_W-1:0] r_drain_q, w_drain_d;
    logic [RB_W-1:0]    r_rb_q, w_rb_d, w_rb_eff;
    logic               r_idx_err_q, w_idx_err_d;
    logic               r_ovl_err_q, w_ovl_err_d;
    logic               r_done_q, w_done_d;
    logic               w_accept, w_flush;

    always_comb begin
        w_state_d   = r_state_q;
        w_exp_idx_d = r_exp_idx_q;
        w_xk_idx_d  = fft_xk_index;
        w_drain_d   = r_drain_q;
        w_rb_d      = r_rb_q;
        w_idx_err_d = r_idx_err_q;
        w_ovl_err_d = r_ovl_err_q;
        w_done_d    = 1'b0;
        w_accept    = 1'b0;
        w_flush     = 1'b0;
        w_rb_eff    = (RangeBin_Num == '0) ? RB_W'(1) : RangeBin_Num;

        // A trigger always wins: it restarts the shot from any state.
        if (trig_start) begin
            w_state_d   = ST_WAIT_FRAME;
            w_rb_d      = RB_W'(1);
            w_idx_err_d = 1'b0;
            w_ovl_err_d = 1'b0;
            w_drain_d   = '0;
            w_flush     = 1'b1;
        end else begin
            case (r_state_q)
                ST_WAIT_FRAME: begin
                    if (fft_dv) begin
                        if (fft_xk_index == '0) begin
                            w_accept    = 1'b1;
                            w_exp_idx_d = IDX_W'(1);
                            w_state_d   = ST_STREAM;
                        end else begin
                            w_idx_err_d = 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (fft_dv) begin
                        w_accept    = 1'b1;
                        w_exp_idx_d = r_exp_idx_q + IDX_W'(1);
                        if (fft_xk_index != r_exp_idx_q) begin
                            w_idx_err_d = 1'b1;
                        end
                        if (fft_xk_index == IDX_W'(FFT_LEN - 1)) begin
                            w_state_d = ST_DRAIN;
                            w_drain_d = '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    w_drain_d = r_drain_q + DRAIN_W'(1);
                    if (fft_dv) begin
                        w_ovl_err_d = 1'b1;
                    end
                    // seq_done lines up with the last power sample leaving the pipe;
                    // the counter only moves once that sample has been written.
                    if (r_drain_q == DRAIN_W'(PIPE_LAT - 2) && r_rb_q >= w_rb_eff) begin
                        w_done_d = 1'b1;
                    end
                    if (r_drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
                        if (r_done_q) begin
                            w_state_d = ST_IDLE;
                        end else begin
                            w_rb_d    = r_rb_q + RB_W'(1);
                            w_state_d = ST_WAIT_FRAME;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_exp_idx_q <= '0;
            r_xk_idx_q  <= '0;
            r_drain_q   <= '0;
            r_rb_q      <= '0;
            r_idx_err_q <= 1'b0;
            r_ovl_err_q <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_exp_idx_q <= w_exp_idx_d;
            r_xk_idx_q  <= w_xk_idx_d;
            r_drain_q   <= w_drain_d;
            r_rb_q      <= w_rb_d;
            r_idx_err_q <= w_idx_err_d;
            r_ovl_err_q <= w_ovl_err_d;
            r_done_q    <= w_done_d;
        end
    end

    spec_power_pipe u_power_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_flush),
        .in_valid  (w_accept),
        .in_index  (fft_xk_index),
        .in_re     (fft_xk_re),
        .in_im     (fft_xk_im),
        .out_valid (data_valid_out),
        .out_index (data_index),
        .out_power (spec_data_out)
    );

    assign xk_index_reg1    = r_xk_idx_q;
    assign RangeBin_Counter = r_rb_q;
    assign seq_busy         = (r_state_q != ST_IDLE);
    assign seq_done         = r_done_q;
    assign index_err        = r_idx_err_q;
    assign overlap_err      = r_ovl_err_q;
endmodule
`default_nettype wire

// File: tb/tb_spec_rangebin_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_spec_rangebin_seq
// Brief  : Randomized self-checking bench for spec_rangebin_seq.
// Rev    : 1.0  initial release
// ============================================================================
module tb_spec_rangebin_seq;
    import spec_rangebin_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              trig_start = 1'b0;
    logic [4:0]        rb_num = '0;
    logic              fft_dv = 1'b0;
    logic [9:0]        fft_xk_index = '0;
    logic signed [15:0] fft_xk_re = '0;
    logic signed [15:0] fft_xk_im = '0;
    logic [9:0]        xk_index_reg1, data_index;
    logic              data_valid_out, seq_busy, seq_done, index_err, overlap_err;
    logic [31:0]       spec_data_out;
    logic [4:0]        RangeBin_Counter;

    spec_rangebin_seq dut (
        .clk(clk), .rst(rst), .trig_start(trig_start), .RangeBin_Num(rb_num),
        .fft_dv(fft_dv), .fft_xk_index(fft_xk_index), .fft_xk_re(fft_xk_re),
        .fft_xk_im(fft_xk_im), .xk_index_reg1(xk_index_reg1), .data_index(data_index),
        .data_valid_out(data_valid_out), .spec_data_out(spec_data_out),
        .RangeBin_Counter(RangeBin_Counter), .seq_busy(seq_busy), .seq_done(seq_done),
        .index_err(index_err), .overlap_err(overlap_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [9:0]  idx;
        logic [31:0] pwr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_errors = 0, cyc = 0;
    int   valid_cnt = 0, done_cnt = 0, last_done_cyc = -1;
    bit   mon_en = 1'b0;
    logic [9:0] prev_idx = '0;
    logic       prev_rst = 1'b1;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_idx <= fft_xk_index;
        prev_rst <= rst;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_power(input int r, input int i);
        longint p;
        p = longint'(r) * longint'(r) + longint'(i) * longint'(i);
        return p[31:0];
    endfunction

    // Output monitor: every cycle is compared against the expected-output schedule.
    always @(negedge clk) begin
        bit due;
        if (mon_en) begin
            due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check_eq("data_valid_out", 32'(data_valid_out), 32'(due));
            if (due) begin
                check_eq("data_index", 32'(data_index), 32'(exp_q[0].idx));
                check_eq("spec_data_out", spec_data_out, exp_q[0].pwr);
                void'(exp_q.pop_front());
            end
            if (data_valid_out) valid_cnt++;
            if (seq_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            check_eq("xk_index_reg1", 32'(xk_index_reg1), prev_rst ? 32'd0 : 32'(prev_idx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fft_dv = 1'b0;
        repeat (n) begin
            fft_xk_index = 10'($urandom);
            tick();
        end
    endtask

    task automatic purge_inflight();
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc) void'(exp_q.pop_back());
    endtask

    task automatic pulse_trig();
        trig_start = 1'b1;
        fft_dv     = 1'b0;
        purge_inflight();
        tick();
        trig_start = 1'b0;
    endtask

    task automatic put_sample(input logic [9:0] idx, input logic signed [15:0] r,
                              input logic signed [15:0] i, input bit accept,
                              input logic [31:0] pwr);
        exp_t e;
        fft_dv = 1'b1; fft_xk_index = idx; fft_xk_re = r; fft_xk_im = i;
        if (accept) begin
            e.cyc = cyc + PIPE_LAT; e.idx = idx; e.pwr = pwr;
            exp_q.push_back(e);
        end
        tick();
        fft_dv = 1'b0;
    endtask

    task automatic rand_sample(input int idx, input bit accept);
        logic signed [15:0] r, i;
        r = 16'($urandom);
        i = 16'($urandom);
        put_sample(10'(idx), r, i, accept, model_power(int'(r), int'(i)));
    endtask

    task automatic send_frame(input int skip, input int stop_at, input bit special,
                              output int last_cyc);
        last_cyc = 0;
        for (int k = 0; k < stop_at; k++) begin
            if (k == skip) continue;
            while ($urandom_range(15) == 0) idle(1);
            last_cyc = cyc;
            if (special && k == 5)      put_sample(10'd5, -16'sd32768, -16'sd32768, 1'b1, 32'h8000_0000);
            else if (special && k == 6) put_sample(10'd6, 16'sd3, -16'sd4, 1'b1, 32'd25);
            else                        rand_sample(k, 1'b1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(seq_busy), 32'd0);
        check_eq({tag, "_counter"}, 32'(RangeBin_Counter), 32'd0);
        check_eq({tag, "_valid"}, 32'(data_valid_out), 32'd0);
        check_eq({tag, "_data"}, spec_data_out, 32'd0);
        check_eq({tag, "_index"}, 32'(data_index), 32'd0);
        check_eq({tag, "_xkreg"}, 32'(xk_index_reg1), 32'd0);
        check_eq({tag, "_done"}, 32'(seq_done), 32'd0);
        check_eq({tag, "_ierr"}, 32'(index_err), 32'd0);
        check_eq({tag, "_oerr"}, 32'(overlap_err), 32'd0);
    endtask

    initial begin
        #5_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last, v0, d0;
        repeat (3) tick();
        check_all_zero("reset");
        mon_en = 1'b1;

        // Three back-to-back bins, trigger on the first edge after reset release.
        rb_num = 5'd3;
        rst    = 1'b0;
        pulse_trig();
        check_eq("s1_counter_trig", 32'(RangeBin_Counter), 32'd1);
        check_eq("s1_busy", 32'(seq_busy), 32'd1);
        v0 = valid_cnt; d0 = done_cnt;
        idle(2);
        for (int b = 1; b <= 3; b++) begin
            check_eq("s1_counter_frame", 32'(RangeBin_Counter), 32'(b));
            send_frame(-1, FFT_LEN, b == 1, last);
            check_eq("s1_counter_stable", 32'(RangeBin_Counter), 32'(b));
            idle(8);
        end
        check_eq("s1_valid_count", 32'(valid_cnt - v0), 32'd3072);
        check_eq("s1_done_count", 32'(done_cnt - d0), 32'd1);
        check_eq("s1_done_cycle", 32'(last_done_cyc), 32'(last + 4));
        check_eq("s1_idle_busy", 32'(seq_busy), 32'd0);
        check_eq("s1_final_counter", 32'(RangeBin_Counter), 32'd3);
        check_eq("s1_ierr", 32'(index_err), 32'd0);

        // Samples in IDLE are ignored silently.
        rand_sample(0, 1'b0);
        idle(2);
        check_eq("idle_dv_busy", 32'(seq_busy), 32'd0);
        check_eq("idle_dv_ierr", 32'(index_err), 32'd0);
        check_eq("idle_dv_oerr", 32'(overlap_err), 32'd0);

        // RangeBin_Num=0 behaves as one bin; frame with index 100 missing.
        rb_num = 5'd0;
        v0 = valid_cnt; d0 = done_cnt;
        pulse_trig();
        idle(3);
        check_eq("s2_ierr_before", 32'(index_err), 32'd0);
        send_frame(100, FFT_LEN, 1'b0, last);
        check_eq("s2_ierr_set", 32'(index_err), 32'd1);
        idle(8);
        check_eq("s2_ierr_sticky", 32'(index_err), 32'd1);
        check_eq("s2_done_count", 32'(done_cnt - d0), 32'd1);
        check_eq("s2_done_cycle", 32'(last_done_cyc), 32'(last + 4));
        check_eq("s2_valid_count", 32'(valid_cnt - v0), 32'd1023);
        check_eq("s2_busy", 32'(seq_busy), 32'd0);

        // Stray sample while waiting, then a sample during the drain window.
        rb_num = 5'd2;
        v0 = valid_cnt; d0 = done_cnt;
        pulse_trig();
        check_eq("s3_ierr_cleared", 32'(index_err), 32'd0);
        rand_sample(7, 1'b0);
        check_eq("s3_ierr_wait", 32'(index_err), 32'd1);
        idle(3);
        send_frame(-1, FFT_LEN, 1'b0, last);
        idle(1);
        rand_sample(0, 1'b0);
        check_eq("s3_oerr", 32'(overlap_err), 32'd1);
        check_eq("s3_counter_drain", 32'(RangeBin_Counter), 32'd1);
        idle(8);
        check_eq("s3_counter_next", 32'(RangeBin_Counter), 32'd2);
        send_frame(-1, FFT_LEN, 1'b0, last);
        idle(8);
        check_eq("s3_done_count", 32'(done_cnt - d0), 32'd1);
        check_eq("s3_done_cycle", 32'(last_done_cyc), 32'(last + 4));
        check_eq("s3_valid_count", 32'(valid_cnt - v0), 32'd2048);
        check_eq("s3_oerr_sticky", 32'(overlap_err), 32'd1);

        // Reset in the middle of bin 2.
        rb_num = 5'd3;
        pulse_trig();
        check_eq("s4_oerr_cleared", 32'(overlap_err), 32'd0);
        idle(2);
        send_frame(-1, FFT_LEN, 1'b0, last);
        idle(8);
        check_eq("s4_counter", 32'(RangeBin_Counter), 32'd2);
        send_frame(-1, 500, 1'b0, last);
        d0 = done_cnt;
        fft_dv = 1'b1; fft_xk_index = 10'd500; rst = 1'b1;
        purge_inflight();
        tick();
        fft_dv = 1'b0;
        check_all_zero("s4_rst");
        rst = 1'b0;
        idle(10);
        check_eq("s4_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("s4_busy", 32'(seq_busy), 32'd0);

        // Re-trigger in the middle of bin 2, then a full two-bin shot.
        rb_num = 5'd2;
        pulse_trig();
        idle(2);
        send_frame(-1, FFT_LEN, 1'b0, last);
        idle(8);
        send_frame(-1, 700, 1'b0, last);
        trig_start = 1'b1; fft_dv = 1'b1; fft_xk_index = 10'd700;
        purge_inflight();
        tick();
        trig_start = 1'b0; fft_dv = 1'b0;
        check_eq("s5_counter_restart", 32'(RangeBin_Counter), 32'd1);
        check_eq("s5_busy", 32'(seq_busy), 32'd1);
        idle(8);
        v0 = valid_cnt; d0 = done_cnt;
        for (int b = 1; b <= 2; b++) begin
            check_eq("s5_counter_frame", 32'(RangeBin_Counter), 32'(b));
            send_frame(-1, FFT_LEN, 1'b0, last);
            idle(8);
        end
        check_eq("s5_valid_count", 32'(valid_cnt - v0), 32'd2048);
        check_eq("s5_done_count", 32'(done_cnt - d0), 32'd1);
        check_eq("s5_done_cycle", 32'(last_done_cyc), 32'(last + 4));
        check_eq("s5_idle", 32'(seq_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spec_rangebin_seq.md
SPEC_RANGEBIN_SEQ -- requirements
Module: spec_rangebin_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all logic; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have input trig_start  1: single-cycle pulse at each laser shot; arms a new shot sequence.
REQ-003 SHALL have input RangeBin_Num  5: number of range bins per shot, 1..31; 0 is treated as 1.
REQ-004 SHALL have inputs fft_dv  1, fft_xk_index  10, fft_xk_re  16 signed, fft_xk_im  16 signed: FFT unload stream, 1024 points per frame.
REQ-005 SHALL have output xk_index_reg1  10: fft_xk_index delayed 1 cycle; read-address source for the accumulator.
REQ-006 SHALL have outputs data_index  10, data_valid_out  1, spec_data_out  32: power sample, its bin index and qualifier, all delayed 4 cycles from the FFT input.
REQ-007 SHALL have output RangeBin_Counter  5: current range bin, counting from 1.
REQ-008 SHALL have outputs seq_busy  1, seq_done  1 (one-cycle pulse), index_err  1 (sticky), overlap_err  1 (sticky).

Function
REQ-009 SHALL implement FSM states IDLE, WAIT_FRAME, STREAM, DRAIN.
REQ-010 IDLE: on trig_start go to WAIT_FRAME, load RangeBin_Counter=1, clear both error flags.
REQ-011 WAIT_FRAME: on fft_dv=1 with fft_xk_index=0 go to STREAM; fft_dv with nonzero index is ignored and sets index_err.
REQ-012 STREAM: each fft_dv sample is accepted; expected index increments by 1; any mismatch sets index_err and the sample is still passed through.
REQ-013 STREAM: fft_dv low inside a frame holds the expected index; no time-out.
REQ-014 STREAM: accepting index 1023 moves to DRAIN.
REQ-015 DRAIN: waits until the delayed copy of index 1023 has left data_valid_out, i.e. 4 cycles.
REQ-016 End of DRAIN: if RangeBin_Counter < effective RangeBin_Num, increment it and go to WAIT_FRAME; otherwise pulse seq_done and go to IDLE.
REQ-017 RangeBin_Counter SHALL change only at the end of DRAIN, so it is stable for every read and write address of a frame.
REQ-018 fft_dv=1 during DRAIN SHALL set overlap_err; the sample is dropped and not counted. The upstream gap between frames is at least 5 cycles.
REQ-019 fft_dv in IDLE SHALL be ignored, with no flag set.
REQ-020 trig_start outside IDLE SHALL restart the sequence: go to WAIT_FRAME with RangeBin_Counter=1 and flush the pipeline valids.
REQ-021 Power SHALL be spec_data_out = re*re + im*im, unsigned 32-bit, with no overflow; the maximum is 2^31 at -32768 on both inputs.
REQ-022 The power pipeline SHALL be 4 registered stages: input register, two multiplies, sum, output.
REQ-023 data_index and data_valid_out SHALL be delay-matched exactly to spec_data_out.
REQ-024 data_valid_out SHALL be 1 only for samples accepted in STREAM.
REQ-025 xk_index_reg1 SHALL register fft_xk_index unconditionally every cycle.
REQ-026 seq_busy SHALL equal (state != IDLE).

Reset
REQ-027 While rst is high at a clock edge, the block SHALL go to IDLE and drive all outputs to 0; RangeBin_Counter=0.
REQ-028 Reset mid-frame SHALL discard all pipeline contents, with no seq_done pulse.
REQ-029 The first clock edge after rst deasserts SHALL be able to accept trig_start.

Structure
REQ-030 A shared package SHALL hold: FFT_LEN=1024, IDX_W=10, RB_W=5, PIPE_LAT=4, the FSM state typedef and the power width (32).
REQ-031 The block SHALL contain one sub-module, spec_power_pipe: the 4-stage magnitude-squared unit carrying a valid/index sideband.

Verification
REQ-032 The bench SHALL cover: RangeBin_Num=3, trig_start, then 3 back-to-back frames of 1024 samples with 8-cycle gaps -> RangeBin_Counter is 1,2,3, 3072 data_valid_out cycles, and a single seq_done 4 cycles after the last sample.
REQ-033 The bench SHALL cover: re=-32768, im=-32768 at index 5 -> spec_data_out=0x80000000 with data_index=5, exactly 4 cycles later; re=3, im=-4 -> 25.
REQ-034 The bench SHALL cover: a frame that skips index 100 -> index_err=1 and stays 1 until the next trig_start; the frame still completes.
REQ-035 The bench SHALL cover: fft_dv 2 cycles after index 1023 -> overlap_err=1, the sample is absent from data_valid_out, and RangeBin_Counter still advances once.
REQ-036 The bench SHALL cover: rst asserted at index 500 of bin 2 -> the next cycle shows all outputs 0, state IDLE, and no seq_done.
REQ-037 The bench SHALL cover: trig_start at index 700 of bin 2 -> RangeBin_Counter=1, in-flight valids flushed, and the next index-0 frame is accepted.
